// File: rtl/munoc_lpi_axi4_outstanding_bridge_pkg.sv
// Shared constants and helpers for the LPI-to-AXI4 outstanding bridge.
package munoc_lpi_axi4_outstanding_bridge_pkg;

  localparam int BW_AXI_LEN   = 8;
  localparam int BW_AXI_SIZE  = 3;
  localparam int BW_AXI_BURST = 2;
  localparam int BW_AXI_RESP  = 2;

  localparam logic [BW_AXI_BURST-1:0] BURST_INCR = 2'b01;
  localparam logic [BW_AXI_RESP-1:0]  RESP_OKAY  = 2'b00;

  // bit positions inside the 2-bit LPI dready vectors
  localparam int DREADY_NOW  = 0;
  localparam int DREADY_NEXT = 1;

  function automatic int burden_width(input int bw_burden);
    return (bw_burden > 1) ? bw_burden : 1;
  endfunction

  // tracker entry = {is_write, burden}
  function automatic int tracker_entry_width(input int bw_burden);
    return 1 + burden_width(bw_burden);
  endfunction

endpackage

// File: rtl/munoc_lpi_axi4_outstanding_bridge_fifo.sv
// Parametrised synchronous FIFO with occupancy count.
// Caller guarantees no push when full and no pop when empty.
// DEPTH must be a power of 2 so pointers wrap naturally.
module munoc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int BW_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BW_CNT = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head_data,
  output logic [BW_CNT-1:0] count,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [BW_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [BW_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [BW_CNT-1:0] count_q, count_d;

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + BW_PTR'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + BW_PTR'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + BW_CNT'(1);
      2'b01:   count_d = count_q - BW_CNT'(1);
      default: count_d = count_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (32'(count_q) == DEPTH);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/munoc_lpi_axi4_outstanding_bridge.sv
// LPI request/response to single-beat AXI4 master bridge with up to
// NUM_OUTSTANDING unretired requests. A tracker FIFO records request order
// ({is_write, burden}); R data is queued in a read-data FIFO and B responses
// are counted, so retirement follows LPI order regardless of R/B ordering.
// Optional macro MUNOC_LPI_BRIDGE_WRITE_RESP_EN: when defined, writes return
// an LPI response (rdata=0); otherwise writes retire silently.
module munoc_lpi_axi4_outstanding_bridge
  import munoc_lpi_axi4_outstanding_bridge_pkg::*;
#(
  parameter int BW_ADDR         = 32,
  parameter int BW_DATA         = 32,
  parameter int BW_SUBDATA      = 8,
  parameter int HAS_BURDEN      = 0,
  parameter int BW_BURDEN       = 1,
  parameter int BW_AXI_TID      = 4,
  parameter int AXI_TID_VALUE   = 0,
  parameter int NUM_OUTSTANDING = 4,
  localparam int BW_PERMIT   = BW_DATA / BW_SUBDATA,
  localparam int BW_STRB     = BW_DATA / 8,
  localparam int BW_BURDEN_I = burden_width(BW_BURDEN)
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    comm_disable,
  output logic [1:0]              rlmqdready,
  input  logic                    rlmqvalid,
  input  logic [BW_ADDR-1:0]      rlmqaddr,
  input  logic                    rlmqwrite,
  input  logic [BW_DATA-1:0]      rlmqwdata,
  input  logic [BW_PERMIT-1:0]    rlmqwpermit,
  input  logic [BW_BURDEN_I-1:0]  rlmqburden,
  input  logic [1:0]              rlmydready,
  output logic                    rlmyvalid,
  output logic [BW_DATA-1:0]      rlmyrdata,
  output logic [BW_BURDEN_I-1:0]  rlmyburden,
  output logic                    resp_error,
  output logic [BW_AXI_TID-1:0]   awid,
  output logic [BW_ADDR-1:0]      awaddr,
  output logic [BW_AXI_LEN-1:0]   awlen,
  output logic [BW_AXI_SIZE-1:0]  awsize,
  output logic [BW_AXI_BURST-1:0] awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [BW_DATA-1:0]      wdata,
  output logic [BW_STRB-1:0]      wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [BW_AXI_TID-1:0]   bid,
  input  logic [BW_AXI_RESP-1:0]  bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [BW_AXI_TID-1:0]   arid,
  output logic [BW_ADDR-1:0]      araddr,
  output logic [BW_AXI_LEN-1:0]   arlen,
  output logic [BW_AXI_SIZE-1:0]  arsize,
  output logic [BW_AXI_BURST-1:0] arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [BW_AXI_TID-1:0]   rid,
  input  logic [BW_DATA-1:0]      rdata,
  input  logic [BW_AXI_RESP-1:0]  rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int BW_TRK    = tracker_entry_width(BW_BURDEN);
  localparam int BW_CNT    = $clog2(NUM_OUTSTANDING + 1);
  localparam int SUB_BYTES = BW_SUBDATA / 8;
  localparam logic [BW_AXI_SIZE-1:0] AXI_SIZE = BW_AXI_SIZE'($clog2(BW_STRB));

  logic                   ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
  logic [BW_ADDR-1:0]     ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [BW_DATA-1:0]     w_data_q, w_data_d;
  logic [BW_STRB-1:0]     w_strb_q, w_strb_d, wstrb_in;
  logic [BW_CNT-1:0]      bcnt_q, bcnt_d;
  logic                   resp_error_q, resp_error_d;
  logic                   ready_en_q, ready_en_d;

  logic                   accept, trk_pop, trk_room, rd_avail, wr_avail, rd_retire, wr_retire;
  logic                   trk_full, trk_empty, rdf_full, rdf_empty;
  logic [BW_TRK-1:0]      trk_head;
  logic [BW_CNT-1:0]      trk_count, rdf_count;
  logic [BW_DATA-1:0]     rdf_head;
  logic [BW_BURDEN_I-1:0] burden_in;
  logic                   head_write;

  // request side: accept while each skid is empty or draining this cycle
  assign trk_room = (32'(trk_count) < NUM_OUTSTANDING) | trk_pop;
  assign rlmqdready[DREADY_NOW] = ready_en_q & ~comm_disable & trk_room
                                & (~ar_valid_q | arready) & (~aw_valid_q | awready)
                                & (~w_valid_q | wready);
  assign rlmqdready[DREADY_NEXT] = ready_en_q & ~comm_disable
                                 & (32'(trk_count) + 2 <= NUM_OUTSTANDING)
                                 & ~ar_valid_q & ~aw_valid_q & ~w_valid_q;
  assign accept    = rlmqvalid & rlmqdready[DREADY_NOW];
  assign burden_in = (HAS_BURDEN != 0) ? rlmqburden : '0;

  // permit bit -> BW_SUBDATA/8 strobe bits
  always_comb begin
    wstrb_in = '0;
    for (int i = 0; i < BW_PERMIT; i++) begin
      wstrb_in[i*SUB_BYTES +: SUB_BYTES] = {SUB_BYTES{rlmqwpermit[i]}};
    end
  end

  munoc_sync_fifo #(.DEPTH(NUM_OUTSTANDING), .WIDTH(BW_TRK)) u_tracker (
    .clk(clk), .rstnn(rstnn), .push(accept), .push_data({rlmqwrite, burden_in}),
    .pop(trk_pop), .head_data(trk_head), .count(trk_count), .full(trk_full), .empty(trk_empty)
  );

  munoc_sync_fifo #(.DEPTH(NUM_OUTSTANDING), .WIDTH(BW_DATA)) u_rdata_fifo (
    .clk(clk), .rstnn(rstnn), .push(rvalid), .push_data(rdata),
    .pop(rd_retire), .head_data(rdf_head), .count(rdf_count), .full(rdf_full), .empty(rdf_empty)
  );

  // retire path, purely from registered tracker/FIFO/bcnt state
  assign head_write = trk_head[BW_TRK-1];
  assign rd_avail   = ~trk_empty & ~head_write & ~rdf_empty;
  assign wr_avail   = ~trk_empty & head_write & (bcnt_q != '0);
  assign rd_retire  = rd_avail & rlmydready[DREADY_NOW];
`ifdef MUNOC_LPI_BRIDGE_WRITE_RESP_EN
  assign rlmyvalid  = rd_avail | wr_avail;
  assign wr_retire  = wr_avail & rlmydready[DREADY_NOW];
`else
  assign rlmyvalid  = rd_avail;
  assign wr_retire  = wr_avail;
`endif
  assign trk_pop    = rd_retire | wr_retire;
  assign rlmyrdata  = rd_avail ? rdf_head : '0;
  assign rlmyburden = rlmyvalid ? trk_head[BW_BURDEN_I-1:0] : '0;
  assign resp_error = resp_error_q;

  // next-state for skids, B counter, error pulse and ready enable
  always_comb begin
    ar_valid_d   = ar_valid_q & ~arready;
    aw_valid_d   = aw_valid_q & ~awready;
    w_valid_d    = w_valid_q & ~wready;
    ar_addr_d    = ar_addr_q;
    aw_addr_d    = aw_addr_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    if (accept && !rlmqwrite) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = rlmqaddr;
    end
    if (accept && rlmqwrite) begin
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      aw_addr_d  = rlmqaddr;
      w_data_d   = rlmqwdata;
      w_strb_d   = wstrb_in;
    end
    case ({bvalid, wr_retire})
      2'b10:   bcnt_d = bcnt_q + BW_CNT'(1);
      2'b01:   bcnt_d = bcnt_q - BW_CNT'(1);
      default: bcnt_d = bcnt_q;
    endcase
    resp_error_d = (rvalid & (rresp != RESP_OKAY)) | (bvalid & (bresp != RESP_OKAY));
    ready_en_d   = 1'b1;
  end

  // state registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      ar_valid_q   <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      ar_addr_q    <= '0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bcnt_q       <= '0;
      resp_error_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      ar_valid_q   <= ar_valid_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      ar_addr_q    <= ar_addr_d;
      aw_addr_q    <= aw_addr_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      bcnt_q       <= bcnt_d;
      resp_error_q <= resp_error_d;
      ready_en_q   <= ready_en_d;
    end
  end

  assign awid    = BW_AXI_TID'(AXI_TID_VALUE);
  assign awaddr  = aw_addr_q;
  assign awlen   = '0;
  assign awsize  = AXI_SIZE;
  assign awburst = BURST_INCR;
  assign awvalid = aw_valid_q;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = w_valid_q;
  assign bready  = 1'b1;
  assign arid    = BW_AXI_TID'(AXI_TID_VALUE);
  assign araddr  = ar_addr_q;
  assign arlen   = '0;
  assign arsize  = AXI_SIZE;
  assign arburst = BURST_INCR;
  assign arvalid = ar_valid_q;
  assign rready  = 1'b1;

  // IDs and rlast carry no information for single-beat fixed-ID traffic
  logic unused_ok;
  assign unused_ok = ^{rid, bid, rlast, rlmydready[DREADY_NEXT], trk_full, rdf_full, rdf_count};

endmodule
